food_placer: RTL and testbench
==============================

FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 SHALL have parameter GRID_W, default 32, grid columns (2..256).
REQ-002 SHALL have parameter GRID_H, default 24, grid rows (2..256).
REQ-003 SHALL have parameter CELL_PX, default 18, pixel pitch of one cell.
REQ-004 SHALL have parameter ORIGIN_PX, default 12, pixel offset of cell 0 on both axes.
REQ-005 SHALL have parameter MAX_TRIES, default 15, random draws per request before giving up (1..255).
REQ-006 SHALL have parameter SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-007 SHALL have ports: clk in 1, single clock; rst in 1, synchronous active-high reset.
REQ-008 SHALL have ports: req in 1 (new-food pulse); busy out 1; valid out 1 (placement pulse); fail out 1 (give-up pulse).
REQ-009 SHALL have ports: cell_x out XW=$clog2(GRID_W); cell_y out YW=$clog2(GRID_H); box_x out 10; box_y out 10 (pixel origin of placed cell).
REQ-010 SHALL have ports: occ_x out XW; occ_y out YW; occ_hit in 1 (snake occupies queried cell, valid one cycle after occ_x/occ_y change).

Function
REQ-011 SHALL run a free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle including IDLE.
REQ-012 SHALL draw candidate x from lfsr[XW-1:0] and y from lfsr[8+YW-1:8]; x and y SHALL use disjoint bits.
REQ-013 SHALL treat a candidate with x>=GRID_W or y>=GRID_H as rejected; this SHALL consume one try.
REQ-014 SHALL implement states IDLE, DRAW, CHECK, DONE, GIVEUP (plus SCAN, SCHK under REQ-027).
REQ-015 IDLE: req=1 -> DRAW, try counter cleared; busy=0 only in IDLE.
REQ-016 DRAW: latch candidate; in range -> drive occ_x/occ_y, go CHECK; out of range -> increment tries, stay DRAW, or GIVEUP if tries reaches MAX_TRIES.
REQ-017 CHECK: occ_hit=0 -> DONE; occ_hit=1 -> increment tries, DRAW, or GIVEUP if tries reaches MAX_TRIES.
REQ-018 DONE: register cell_x/cell_y from candidate, valid=1 for exactly one cycle, -> IDLE.
REQ-019 Minimum latency: req sampled in cycle N -> valid high in cycle N+3.
REQ-020 req while busy=1 SHALL be ignored (not queued).
REQ-021 box_x SHALL equal cell_x*CELL_PX+ORIGIN_PX; box_y SHALL equal cell_y*CELL_PX+ORIGIN_PX, each zero-extended/truncated to 10 bits, combinational from registered cells.
REQ-022 cell_x/cell_y/box_x/box_y SHALL hold their last placement until the next valid.
REQ-023 GIVEUP (macro absent): fail=1 one cycle, cell outputs unchanged, -> IDLE.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, lfsr=SEED, tries=0, cell_x=0, cell_y=0, occ_x=0, occ_y=0, valid=0, fail=0, busy=0, from any state including mid-search.
REQ-025 LFSR SHALL never reach zero; no request SHALL be lost silently except per REQ-020 and REQ-024.

Configuration
REQ-026 Macro FOOD_PLACER_SCAN_FALLBACK_EN selects the give-up behaviour.
REQ-027 Defined: exhausting MAX_TRIES -> SCAN; raster from (0,0), x fastest; SCAN drives occ_x/occ_y, SCHK samples occ_hit; free -> DONE with that cell; occupied -> next cell; after (GRID_W-1,GRID_H-1) occupied -> fail pulse, -> IDLE. Undefined: REQ-023; SCAN/SCHK absent.

Structure
REQ-028 A shared package food_pkg SHALL hold the state enum, LFSR polynomial mask, and default SEED.
REQ-029 Sub-module lfsr16 (enable-free, synchronous reset to SEED) SHALL be instantiated once.
REQ-030 Elaboration SHALL error if (GRID_W-1)*CELL_PX+ORIGIN_PX >= 1024 or the same for GRID_H.

Verification
REQ-031 Reset, occ_hit tied 0, req pulse -> valid at N+3, cell in range, box_x=cell_x*18+12.
REQ-032 occ_hit=1 for the first 2 queries then 0 -> valid at N+7 (plus rejected out-of-range draws), fail never asserted.
REQ-033 occ_hit tied 1, macro absent, MAX_TRIES=4 -> fail one cycle, cell outputs unchanged, busy falls.
REQ-034 GRID_W=GRID_H=4, macro defined, occ_hit=1 except cell (3,2) -> valid with cell_x=3, cell_y=2, box_x=66, box_y=48.
REQ-035 rst pulsed during CHECK -> next cycle IDLE, all outputs zero, lfsr=16'hACE1; req during busy produces no second valid.

Source files
------------

// File: rtl/food_pkg.sv
// ============================================================================
// Module      : food_pkg
// Description : Shared types and constants for the food placer. The SCAN and
//               SCHK states exist only when FOOD_PLACER_SCAN_FALLBACK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package food_pkg;

    localparam logic [15:0] c_lfsr_poly    = 16'hB400;
    localparam logic [15:0] c_default_seed = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAW   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_DONE   = 3'd3,
        ST_GIVEUP = 3'd4
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
        ,
        ST_SCAN   = 3'd5,
        ST_SCHK   = 3'd6
`endif
    } state_t;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ c_lfsr_poly) : (s >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Galois LFSR, synchronous reset to SEED.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
    import food_pkg::*;
#(
    parameter logic [15:0] SEED = c_default_seed
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign value = r_state;

endmodule

`default_nettype wire

// File: rtl/food_placer.sv
// ============================================================================
// Module      : food_placer
// Description : Picks a random free grid cell for new food using an LFSR and a
//               one-cycle occupancy lookup. Define FOOD_PLACER_SCAN_FALLBACK_EN
//               to raster-scan the grid after MAX_TRIES failed random draws.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module food_placer
    import food_pkg::*;
#(
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 24,
    parameter int          CELL_PX   = 18,
    parameter int          ORIGIN_PX = 12,
    parameter int          MAX_TRIES = 15,
    parameter logic [15:0] SEED      = c_default_seed,
    localparam int         XW        = $clog2(GRID_W),
    localparam int         YW        = $clog2(GRID_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    output logic          busy,
    output logic          valid,
    output logic          fail,
    output logic [XW-1:0] cell_x,
    output logic [YW-1:0] cell_y,
    output logic [9:0]    box_x,
    output logic [9:0]    box_y,
    output logic [XW-1:0] occ_x,
    output logic [YW-1:0] occ_y,
    input  logic          occ_hit
);

    if (GRID_W < 2 || GRID_W > 256) begin : g_chk_grid_w
        $error("food_placer: GRID_W out of range");
    end
    if (GRID_H < 2 || GRID_H > 256) begin : g_chk_grid_h
        $error("food_placer: GRID_H out of range");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_chk_tries
        $error("food_placer: MAX_TRIES out of range");
    end
    if (SEED == 16'h0000) begin : g_chk_seed
        $error("food_placer: SEED must be nonzero");
    end
    if ((GRID_W - 1) * CELL_PX + ORIGIN_PX >= 1024) begin : g_chk_px_w
        $error("food_placer: box_x does not fit in 10 bits");
    end
    if ((GRID_H - 1) * CELL_PX + ORIGIN_PX >= 1024) begin : g_chk_px_h
        $error("food_placer: box_y does not fit in 10 bits");
    end

    state_t        r_state;
    logic [7:0]    r_tries;
    logic [XW-1:0] r_cell_x;
    logic [YW-1:0] r_cell_y;
    logic [XW-1:0] r_occ_x;
    logic [YW-1:0] r_occ_y;
    logic          r_valid;
    logic          r_fail;
    logic          r_busy;

    logic [15:0]   w_lfsr;
    logic [XW-1:0] w_cand_x;
    logic [YW-1:0] w_cand_y;
    logic          w_in_range;
    logic [7:0]    w_tries_inc;
    logic          w_tries_last;
    logic          w_exhaust;
    logic          w_unused_lfsr;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (w_lfsr)
    );

    // x and y come from disjoint LFSR bytes so they are not correlated
    assign w_cand_x      = w_lfsr[XW-1:0];
    assign w_cand_y      = w_lfsr[8 +: YW];
    assign w_unused_lfsr = ^w_lfsr;
    assign w_in_range    = (32'(w_cand_x) < GRID_W) && (32'(w_cand_y) < GRID_H);
    assign w_tries_inc   = r_tries + 8'd1;
    assign w_tries_last  = (w_tries_inc == 8'(MAX_TRIES));
    assign w_exhaust     = w_tries_last &&
                           (((r_state == ST_DRAW) && !w_in_range) ||
                            ((r_state == ST_CHECK) && occ_hit));

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
    logic [XW-1:0] r_scan_x;
    logic [YW-1:0] r_scan_y;
    logic          w_scan_last_x;
    logic          w_scan_last;

    assign w_scan_last_x = (32'(r_scan_x) == GRID_W - 1);
    assign w_scan_last   = w_scan_last_x && (32'(r_scan_y) == GRID_H - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tries  <= '0;
            r_cell_x <= '0;
            r_cell_y <= '0;
            r_occ_x  <= '0;
            r_occ_y  <= '0;
            r_valid  <= 1'b0;
            r_fail   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            r_scan_x <= '0;
            r_scan_y <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_fail  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_state <= ST_DRAW;
                        r_tries <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (w_in_range) begin
                        r_occ_x <= w_cand_x;
                        r_occ_y <= w_cand_y;
                        r_state <= ST_CHECK;
                    end else begin
                        r_tries <= w_tries_inc;
                    end
                end
                ST_CHECK: begin
                    if (!occ_hit) begin
                        r_cell_x <= r_occ_x;
                        r_cell_y <= r_occ_y;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_tries <= w_tries_inc;
                        r_state <= ST_DRAW;
                    end
                end
                ST_DONE, ST_GIVEUP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
                ST_SCAN: begin
                    r_occ_x <= r_scan_x;
                    r_occ_y <= r_scan_y;
                    r_state <= ST_SCHK;
                end
                ST_SCHK: begin
                    if (!occ_hit) begin
                        r_cell_x <= r_occ_x;
                        r_cell_y <= r_occ_y;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (w_scan_last) begin
                        r_fail  <= 1'b1;
                        r_state <= ST_GIVEUP;
                    end else begin
                        if (w_scan_last_x) begin
                            r_scan_x <= '0;
                            r_scan_y <= r_scan_y + YW'(1);
                        end else begin
                            r_scan_x <= r_scan_x + XW'(1);
                        end
                        r_state <= ST_SCAN;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Running out of random draws overrides the per-state transition
            if (w_exhaust) begin
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
                r_state  <= ST_SCAN;
                r_scan_x <= '0;
                r_scan_y <= '0;
`else
                r_state  <= ST_GIVEUP;
                r_fail   <= 1'b1;
`endif
            end
        end
    end

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign fail   = r_fail;
    assign cell_x = r_cell_x;
    assign cell_y = r_cell_y;
    assign occ_x  = r_occ_x;
    assign occ_y  = r_occ_y;
    assign box_x  = 10'(32'(r_cell_x) * CELL_PX + ORIGIN_PX);
    assign box_y  = 10'(32'(r_cell_y) * CELL_PX + ORIGIN_PX);

endmodule

`default_nettype wire

// File: tb/tb_food_placer.sv
// ============================================================================
// Module      : tb_food_placer
// Description : Randomized self-checking bench for food_placer (default grid
//               and a 4x4 grid with MAX_TRIES=4) against a placement predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_food_placer;

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
    localparam bit c_scan_en = 1'b1;
`else
    localparam bit c_scan_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_b, req_s;
    logic       busy_b, valid_b, fail_b, hit_b;
    logic       busy_s, valid_s, fail_s, hit_s;
    logic [4:0] cx_b, cy_b, ox_b, oy_b;
    logic [1:0] cx_s, cy_s, ox_s, oy_s;
    logic [9:0] bx_b, by_b, bx_s, by_s;

    int vectors = 0;
    int miscompares = 0;

    bit occ_big[1024];
    bit occ_small[16];
    int last_x[2];
    int last_y[2];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    assign hit_b = occ_big[int'(oy_b) * 32 + int'(ox_b)];
    assign hit_s = occ_small[int'(oy_s) * 4 + int'(ox_s)];

    food_placer u_big (
        .clk(clk), .rst(rst), .req(req_b), .busy(busy_b), .valid(valid_b), .fail(fail_b),
        .cell_x(cx_b), .cell_y(cy_b), .box_x(bx_b), .box_y(by_b),
        .occ_x(ox_b), .occ_y(oy_b), .occ_hit(hit_b)
    );

    food_placer #(.GRID_W(4), .GRID_H(4), .MAX_TRIES(4)) u_small (
        .clk(clk), .rst(rst), .req(req_s), .busy(busy_s), .valid(valid_s), .fail(fail_s),
        .cell_x(cx_s), .cell_y(cy_s), .box_x(bx_s), .box_y(by_s),
        .occ_x(ox_s), .occ_y(oy_s), .occ_hit(hit_s)
    );

    // Reference LFSR: shift right, fold taps x^16,x^14,x^13,x^11 back in on a 1 out
    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= model_step(m_lfsr);
    end

    function automatic bit occupied(input int sel, input int x, input int y);
        return (sel == 0) ? occ_big[y * 32 + x] : occ_small[y * 4 + x];
    endfunction

    // Walks the draw rules from the LFSR value seen in the first DRAW cycle
    task automatic predict(input int sel, input logic [15:0] l1, output int kind,
                           output int dly, output int ex, output int ey);
        int gw, gh, xw, yw, mt, t, tries, tx, x, y;
        logic [15:0] l;
        gw = (sel == 0) ? 32 : 4;  gh = (sel == 0) ? 24 : 4;
        xw = (sel == 0) ? 5 : 2;   yw = (sel == 0) ? 5 : 2;
        mt = (sel == 0) ? 15 : 4;
        l = l1; t = 1; tries = 0; tx = -1;
        kind = 0; dly = 0; ex = last_x[sel]; ey = last_y[sel];
        while (tx < 0 && kind == 0) begin
            x = int'(l) % (1 << xw);
            y = (int'(l) >> 8) % (1 << yw);
            if (x >= gw || y >= gh) begin
                tries++;
                if (tries == mt) tx = t + 1;
                else begin t++; l = model_step(l); end
            end else if (!occupied(sel, x, y)) begin
                kind = 1; dly = t + 2; ex = x; ey = y;
            end else begin
                tries++;
                if (tries == mt) tx = t + 2;
                else begin t += 2; l = model_step(model_step(l)); end
            end
        end
        if (kind == 0) begin
            if (c_scan_en) begin
                for (int i = 0; i < gw * gh; i++) begin
                    if (kind == 0 && !occupied(sel, i % gw, i / gw)) begin
                        kind = 1; dly = tx + 2 + 2 * i; ex = i % gw; ey = i / gw;
                    end
                end
                if (kind == 0) begin kind = 2; dly = tx + 2 * gw * gh; end
            end else begin
                kind = 2; dly = tx;
            end
        end
    endtask

    task automatic sample(input int sel, output logic v, output logic f, output logic b,
                          output int cx, output int cy, output int bx, output int by);
        if (sel == 0) begin
            v = valid_b; f = fail_b; b = busy_b;
            cx = int'(cx_b); cy = int'(cy_b); bx = int'(bx_b); by = int'(by_b);
        end else begin
            v = valid_s; f = fail_s; b = busy_s;
            cx = int'(cx_s); cy = int'(cy_s); bx = int'(bx_s); by = int'(by_s);
        end
    endtask

    task automatic set_req(input int sel, input logic val);
        if (sel == 0) req_b = val; else req_s = val;
    endtask

    task automatic clear_grid(input int sel, input bit val);
        if (sel == 0) foreach (occ_big[i]) occ_big[i] = val;
        else          foreach (occ_small[i]) occ_small[i] = val;
    endtask

    // One request on instance sel; req held for 'hold' cycles; mark2 occupies
    // the first two in-range cells the draw sequence will query
    task automatic run_req(input int sel, input int hold, input bit mark2, input string name);
        logic [15:0] l1, l;
        int kind, dly, ex, ey, okind, extra, marked, x, y;
        logic v, f, b;
        int cx, cy, bx, by;
        bit seen;
        @(negedge clk);
        l1 = model_step(m_lfsr);
        if (mark2) begin
            clear_grid(sel, 1'b0);
            l = l1; marked = 0;
            for (int k = 0; k < 200 && marked < 2; k++) begin
                x = int'(l) % 32; y = (int'(l) >> 8) % 32;
                if (y >= 24) l = model_step(l);
                else begin occ_big[y * 32 + x] = 1'b1; marked++; l = model_step(model_step(l)); end
            end
        end
        predict(sel, l1, kind, dly, ex, ey);
        set_req(sel, 1'b1);
        seen = 1'b0;
        for (int d = 1; d <= 400 && !seen; d++) begin
            @(negedge clk);
            if (d >= hold) set_req(sel, 1'b0);
            sample(sel, v, f, b, cx, cy, bx, by);
            vectors++;
            if (b !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy at +%0d: got %b want 1", name, d, b);
            end
            if (v === 1'b1 || f === 1'b1) begin
                seen = 1'b1;
                okind = (v === 1'b1 && f === 1'b1) ? 3 : (v === 1'b1 ? 1 : 2);
                vectors++;
                if (okind !== kind) begin
                    miscompares++;
                    $display("FAIL %s outcome: got %0d want %0d (1=valid 2=fail)", name, okind, kind);
                end
                vectors++;
                if (d !== dly) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d want %0d", name, d, dly);
                end
                vectors++;
                if (cx !== ex || cy !== ey) begin
                    miscompares++;
                    $display("FAIL %s cell: got (%0d,%0d) want (%0d,%0d)", name, cx, cy, ex, ey);
                end
                vectors++;
                if (bx !== ((ex * 18 + 12) & 1023) || by !== ((ey * 18 + 12) & 1023)) begin
                    miscompares++;
                    $display("FAIL %s box: got (%0d,%0d) want (%0d,%0d)", name, bx, by,
                             (ex * 18 + 12) & 1023, (ey * 18 + 12) & 1023);
                end
                if (kind == 1) begin last_x[sel] = ex; last_y[sel] = ey; end
            end
        end
        set_req(sel, 1'b0);
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no valid/fail want one within 400 cycles", name);
        end
        @(negedge clk);
        sample(sel, v, f, b, cx, cy, bx, by);
        vectors++;
        if (b !== 1'b0 || v !== 1'b0 || f !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after-event: got busy=%b valid=%b fail=%b want 0 0 0", name, b, v, f);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            sample(sel, v, f, b, cx, cy, bx, by);
            if (v === 1'b1 || f === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL %s extra pulses: got %0d want 0", name, extra);
        end
    endtask

    task automatic check_idle_zero(input string name);
        vectors++;
        if (busy_b !== 1'b0 || valid_b !== 1'b0 || fail_b !== 1'b0) begin
            miscompares++;
            $display("FAIL %s flags: got busy=%b valid=%b fail=%b want 0 0 0", name, busy_b, valid_b, fail_b);
        end
        vectors++;
        if (cx_b !== 5'd0 || cy_b !== 5'd0 || ox_b !== 5'd0 || oy_b !== 5'd0) begin
            miscompares++;
            $display("FAIL %s cells: got cell=(%0d,%0d) occ=(%0d,%0d) want zeros", name, cx_b, cy_b, ox_b, oy_b);
        end
        vectors++;
        if (bx_b !== 10'd12 || by_b !== 10'd12) begin
            miscompares++;
            $display("FAIL %s box: got (%0d,%0d) want (12,12)", name, bx_b, by_b);
        end
        vectors++;
        if (u_big.w_lfsr !== 16'hACE1) begin
            miscompares++;
            $display("FAIL %s lfsr: got %h want ace1", name, u_big.w_lfsr);
        end
        vectors++;
        if (busy_s !== 1'b0 || cx_s !== 2'd0 || cy_s !== 2'd0) begin
            miscompares++;
            $display("FAIL %s small: got busy=%b cell=(%0d,%0d) want 0 (0,0)", name, busy_s, cx_s, cy_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        last_x = '{0, 0}; last_y = '{0, 0};
    endtask

    task automatic test_single();
        clear_grid(0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_req(0, 1, 1'b0, "single");
        end
    endtask

    task automatic test_retry();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_req(0, 1, 1'b1, "retry");
        end
        clear_grid(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        repeat ($urandom_range(0, 5)) @(negedge clk);
        run_req(0, 3, 1'b0, "back_to_back");
    endtask

    task automatic test_giveup();
        clear_grid(1, 1'b0);
        run_req(1, 1, 1'b0, "small_place");
        clear_grid(1, 1'b1);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        run_req(1, 1, 1'b0, "giveup");
    endtask

    task automatic test_scan_cell();
        clear_grid(1, 1'b1);
        occ_small[2 * 4 + 3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_req(1, 1, 1'b0, "one_free_cell");
        end
    endtask

    task automatic test_reset_mid();
        int nvalid;
        clear_grid(0, 1'b0);
        @(negedge clk);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_x = '{0, 0}; last_y = '{0, 0};
        check_idle_zero("reset_mid");
        nvalid = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid_b === 1'b1 || busy_b === 1'b1) nvalid++;
        end
        vectors++;
        if (nvalid !== 0) begin
            miscompares++;
            $display("FAIL reset_mid activity: got %0d cycles want 0", nvalid);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_b = 1'b0;
        req_s = 1'b0;
        clear_grid(0, 1'b0);
        clear_grid(1, 1'b0);
        test_reset();
        test_single();
        test_retry();
        test_back_to_back();
        test_giveup();
        test_scan_cell();
        test_reset_mid();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
